sram_bus_ctrl: RTL and testbench
================================

SRAM_BUS_CTRL -- requirements
Module: sram_bus_ctrl

Synchronous request/response front-end driving an asynchronous single-port SRAM (cs/we/oe/addr/data pins) with programmable setup, access and hold phases.

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8: SRAM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: SRAM data width.
REQ-003 The block SHALL have parameter RD_WAIT, default 3: cycles cs/oe held active per read, legal range >= 1.
REQ-004 The block SHALL have parameter WR_WAIT, default 2: cycles cs/we held active per write, legal range >= 1.
REQ-005 The block SHALL have port clk_i, input, 1: single clock, all state on rising edge.
REQ-006 The block SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-007 The block SHALL have port req_valid_i, input, 1: request valid.
REQ-008 The block SHALL have port req_ready_o, output, 1: request accepted when valid and ready are both high at a clock edge.
REQ-009 The block SHALL have port req_we_i, input, 1: 1 = write, 0 = read.
REQ-010 The block SHALL have port req_addr_i, input, ADDR_WIDTH: access address.
REQ-011 The block SHALL have port req_wdata_i, input, DATA_WIDTH: write data.
REQ-012 The block SHALL have port rsp_valid_o, output, 1: response valid.
REQ-013 The block SHALL have port rsp_ready_i, input, 1: response consumed when valid and ready are both high.
REQ-014 The block SHALL have port rsp_rdata_o, output, DATA_WIDTH: read data (0 for write responses).
REQ-015 The block SHALL have ports sram_cs_o, sram_we_o and sram_oe_o, each output, 1: SRAM controls, active high.
REQ-016 The block SHALL have port sram_addr_o, output, ADDR_WIDTH: SRAM address.
REQ-017 The block SHALL have port sram_data_o, output, DATA_WIDTH: write data toward the SRAM.
REQ-018 The block SHALL have port sram_data_oe_o, output, 1: enable for the external tristate driver.
REQ-019 The block SHALL have port sram_data_i, input, DATA_WIDTH: data read back from the SRAM pins.

Function
REQ-020 The FSM SHALL have states IDLE, SETUP, ACCESS, HOLD and RESP.
REQ-021 req_ready_o SHALL be 1 only in IDLE.
REQ-022 On accept, the FSM SHALL latch we, addr and wdata, and move to SETUP.
REQ-023 All sram_* outputs SHALL be driven from flops, with no combinational path from req_* inputs.
REQ-024 SETUP SHALL last 1 cycle: addr driven, cs=we=oe=0, data_oe=we_latched, data_o=wdata_latched.
REQ-025 ACCESS SHALL last RD_WAIT cycles for a read (cs=1, oe=1, we=0) and WR_WAIT cycles for a write (cs=1, we=1, oe=0, data_oe=1).
REQ-026 A down-counter of width $clog2(max(RD_WAIT,WR_WAIT)+1) SHALL time ACCESS; it is loaded on entry and the FSM exits ACCESS when the count reaches 1.
REQ-027 For reads, rsp_rdata_o SHALL capture sram_data_i on the clock edge that leaves ACCESS.
REQ-028 HOLD SHALL last 1 cycle: cs=we=oe=0, addr held; for writes data_oe=1 and data_o held; for reads data_oe=0.
REQ-029 After HOLD the FSM SHALL go to RESP with rsp_valid_o=1; it stays in RESP until rsp_ready_i=1, then returns to IDLE.
REQ-030 rsp_valid_o SHALL rise N+2 edges after the accepting edge (N = RD_WAIT or WR_WAIT).
REQ-031 rsp_rdata_o SHALL be stable while rsp_valid_o=1.
REQ-032 The next request SHALL be accepted no earlier than the edge following the response handshake.
REQ-033 Every write SHALL produce exactly one response, with rsp_rdata_o=0.
REQ-034 sram_we_o and sram_oe_o SHALL never be 1 simultaneously.
REQ-035 sram_oe_o and sram_data_oe_o SHALL never be 1 simultaneously.
REQ-036 sram_addr_o SHALL not change while sram_cs_o=1 or in HOLD.
REQ-037 RD_WAIT<1 or WR_WAIT<1 SHALL be an elaboration-time $fatal.

Reset
REQ-038 While rst_ni=0, state=IDLE, sram_cs_o=sram_we_o=sram_oe_o=sram_data_oe_o=0, sram_addr_o=0, sram_data_o=0, rsp_valid_o=0, rsp_rdata_o=0, counter=0.
REQ-039 Reset asserted mid-operation (any state) SHALL clear all outputs immediately without waiting for a clock edge, and SHALL drop any pending request or response.
REQ-040 After rst_ni rises, req_ready_o=1 on the first cycle.

Verification (RD_WAIT=3, WR_WAIT=2, 8/8 widths)
REQ-041 Write addr 0x12 data 0xA5 -> 1 cycle SETUP, then cs=we=1 for exactly 2 cycles, data_oe=1 for 4 cycles, rsp_valid at accept+4 edges, rdata=0x00.
REQ-042 Read addr 0x12 with SRAM model returning 0xA5 -> cs=oe=1 for exactly 3 cycles, rsp_valid at accept+5 edges, rdata=0xA5, data_oe=0 throughout.
REQ-043 Response backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rdata held, req_ready_o=0; the request offered meanwhile is accepted only after the handshake.
REQ-044 Reset pulse during ACCESS of a write -> cs/we/data_oe drop asynchronously; no response is produced; the next read of that address passes cleanly.
REQ-045 Random 1000-op mix against the SRAM model with a scoreboard -> all reads match the last written data; we/oe overlap assertion never fires.

Source files
------------

// File: rtl/sram_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sram_bus_ctrl
// Brief   : valid/ready request front-end for an async single-port SRAM with
//           fixed setup/hold and parameterised access phases.
// Revision: 1.0
// ============================================================================
module sram_bus_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RD_WAIT    = 3,
  parameter int WR_WAIT    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  sram_cs_o,
  output logic                  sram_we_o,
  output logic                  sram_oe_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_data_o,
  output logic                  sram_data_oe_o,
  input  logic [DATA_WIDTH-1:0] sram_data_i
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WR_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  generate
    if (RD_WAIT < 1 || WR_WAIT < 1) begin : g_bad_wait
      $fatal(1, "sram_bus_ctrl: RD_WAIT and WR_WAIT must both be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_HOLD   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  cs_q, cs_d;
  logic                  wen_q, wen_d;
  logic                  oe_q, oe_d;
  logic                  doe_q, doe_d;

  // Pin controls are computed for the state being entered so that every
  // sram_* output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cs_d    = 1'b0;
    wen_d   = 1'b0;
    oe_d    = 1'b0;
    doe_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_SETUP;
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          doe_d   = req_we_i;
          rdata_d = '0;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = we_q ? WR_CNT : RD_CNT;
        cs_d    = 1'b1;
        wen_d   = we_q;
        oe_d    = ~we_q;
        doe_d   = we_q;
      end
      S_ACCESS: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          doe_d   = we_q;
          if (!we_q) begin
            rdata_d = sram_data_i;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          cs_d  = 1'b1;
          wen_d = we_q;
          oe_d  = ~we_q;
          doe_d = we_q;
        end
      end
      S_HOLD: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cs_q    <= 1'b0;
      wen_q   <= 1'b0;
      oe_q    <= 1'b0;
      doe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      wen_q   <= wen_d;
      oe_q    <= oe_d;
      doe_q   <= doe_d;
    end
  end

  assign req_ready_o    = (state_q == S_IDLE);
  assign rsp_valid_o    = (state_q == S_RESP);
  assign rsp_rdata_o    = rdata_q;
  assign sram_cs_o      = cs_q;
  assign sram_we_o      = wen_q;
  assign sram_oe_o      = oe_q;
  assign sram_addr_o    = addr_q;
  assign sram_data_o    = wdata_q;
  assign sram_data_oe_o = doe_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_bus_ctrl
// Brief   : self-checking bench for sram_bus_ctrl with an SRAM model and a
//           scoreboard of last-written data per address.
// Revision: 1.0
// ============================================================================
module tb_sram_bus_ctrl;

  localparam int RD_N = 3;
  localparam int WR_N = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       sram_cs, sram_we, sram_oe, sram_doe;
  logic [7:0] sram_addr, sram_dout, sram_din;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem  [256];
  logic [7:0] rmem [256];

  always #5 clk = ~clk;

  sram_bus_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_WAIT(RD_N), .WR_WAIT(WR_N)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .sram_cs_o(sram_cs), .sram_we_o(sram_we), .sram_oe_o(sram_oe),
    .sram_addr_o(sram_addr), .sram_data_o(sram_dout), .sram_data_oe_o(sram_doe),
    .sram_data_i(sram_din)
  );

  // Asynchronous SRAM: drives data only while selected for read, stores mid-cycle.
  assign sram_din = (sram_cs && sram_oe) ? mem[sram_addr] : 8'hEE;
  always @(negedge clk) if (sram_cs && sram_we) mem[sram_addr] = sram_dout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bus-level invariants checked every cycle outside reset.
  logic       prev_cs = 1'b0;
  logic [7:0] prev_addr = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if ((sram_we && sram_oe) || (sram_oe && sram_doe)) begin
        bad++;
        $display("FAIL overlap: we=%0b oe=%0b data_oe=%0b", sram_we, sram_oe, sram_doe);
      end
      if (prev_cs && (sram_addr !== prev_addr)) begin
        bad++;
        $display("FAIL addr_stable: got %0h expected %0h", sram_addr, prev_addr);
      end
      prev_cs   = sram_cs;
      prev_addr = sram_addr;
    end else begin
      prev_cs = 1'b0;
    end
  end

  bit         offer = 1'b0;
  logic [7:0] offer_addr = '0;

  task automatic do_op(input bit we, input logic [7:0] a, input logic [7:0] d, input int bp,
                       output logic [7:0] rd, output int lat, output int ncs, output int nwe,
                       output int noe, output int ndoe, output bit hung);
    int k;
    hung = 1'b0; lat = 0; ncs = 0; nwe = 0; noe = 0; ndoe = 0; rd = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    #1;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); #1; k++; end
    if (!req_ready) begin hung = 1'b1; req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!rsp_valid && lat < 40) begin
      ncs += int'(sram_cs); nwe += int'(sram_we); noe += int'(sram_oe); ndoe += int'(sram_doe);
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) begin hung = 1'b1; return; end
    rd = rsp_rdata;
    for (int i = 0; i < bp; i++) begin
      if (offer) begin req_valid = 1'b1; req_we = 1'b0; req_addr = offer_addr; end
      @(posedge clk); #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, rd);
      chk("bp_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("hs_valid_drop", rsp_valid, 0);
    chk("hs_ready_back", req_ready, 1);
  endtask

  // Expected timing comes straight from the phase lengths: 1 setup, N access, 1 hold.
  task automatic op_check(input string nm, input bit we, input logic [7:0] a,
                          input logic [7:0] d, input int bp, input logic [7:0] exp_rd);
    logic [7:0] rd;
    int lat, ncs, nwe, noe, ndoe, n;
    bit hung;
    n = we ? WR_N : RD_N;
    do_op(we, a, d, bp, rd, lat, ncs, nwe, noe, ndoe, hung);
    chk({nm, "_timeout"}, hung, 0);
    if (!hung) begin
      chk({nm, "_rdata"}, rd, exp_rd);
      chk({nm, "_latency"}, lat, n + 2);
      chk({nm, "_cs_cycles"}, ncs, n);
      chk({nm, "_we_cycles"}, nwe, we ? n : 0);
      chk({nm, "_oe_cycles"}, noe, we ? 0 : n);
      chk({nm, "_doe_cycles"}, ndoe, we ? n + 2 : 0);
    end
    if (we) rmem[a] = d;
  endtask

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    int         bp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = '0; rmem[i] = '0; end
    tbl[0] = '{1'b1, 8'h12, 8'hA5, 8'h00, 0};
    tbl[1] = '{1'b0, 8'h12, 8'h00, 8'hA5, 0};
    tbl[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 1};
    tbl[3] = '{1'b0, 8'h00, 8'h5A, 8'hFF, 0};
    tbl[4] = '{1'b1, 8'hFF, 8'h01, 8'h00, 0};
    tbl[5] = '{1'b0, 8'hFF, 8'h00, 8'h01, 2};
    tbl[6] = '{1'b0, 8'h77, 8'h00, 8'h00, 0};
    tbl[7] = '{1'b0, 8'h12, 8'h00, 8'hA5, 0};

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cs", sram_cs, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_oe", sram_oe, 0);
    chk("rst_doe", sram_doe, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dout", sram_dout, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("post_rst_ready", req_ready, 1);

    for (int i = 0; i < 8; i++)
      op_check($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].bp, tbl[i].exp_rd);

    // Backpressure with a request offered while the response is pending.
    offer = 1'b1; offer_addr = 8'h00;
    op_check("bp_read", 1'b0, 8'h12, 8'h00, 5, 8'hA5);
    offer = 1'b0;
    op_check("bp_next", 1'b0, 8'h00, 8'h00, 0, 8'hFF);

    // Reset pulse during the access phase of a write.
    op_check("pre_abort_wr", 1'b1, 8'h40, 8'h3C, 0, 8'h00);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h40; req_wdata = 8'h77;
    #1;
    chk("abort_accept_ready", req_ready, 1);
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #2;
    chk("abort_cs_active", sram_cs, 1);
    chk("abort_we_active", sram_we, 1);
    rst_n = 1'b0; #1;
    chk("abort_cs", sram_cs, 0);
    chk("abort_we", sram_we, 0);
    chk("abort_doe", sram_doe, 0);
    chk("abort_addr", sram_addr, 0);
    chk("abort_rsp", rsp_valid, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("abort_ready_first", req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", rsp_valid, 0);
    end
    op_check("abort_readback", 1'b0, 8'h40, 8'h00, 0, 8'h3C);

    // Randomised mix against the scoreboard.
    for (int i = 0; i < 1000; i++) begin
      bit         w;
      logic [7:0] a, d;
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      op_check("rand", w, a, d, int'($urandom_range(0, 2)), w ? 8'h00 : rmem[a]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
